simon_game_ctrl: RTL and testbench
==================================

# simon_game_ctrl

Game sequencer for the Simon design: owns the round state machine, regenerates the pseudo-random colour sequence from a stored seed, schedules LED/tone playback against a millisecond tick, and checks player presses. Sits between the debounced button inputs and the LED, tone-generator and score-display datapaths. It drives request signals only; tone synthesis and 7-segment multiplexing are downstream.

## Interface
- MAX_LEN, 32: sequence length that wins the game (2..99).
- ON_TICKS, 300: ticks each colour is shown during playback and press feedback.
- GAP_TICKS, 100: dark ticks after each shown colour.
- LOSE_TICKS, 1000: ticks the error tone sounds.
- TIMEOUT_TICKS, 3000: ticks allowed between player presses (only with macro).
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- tick  in  1  single-cycle pulse, nominally 1 ms period.
- btn  in  4  debounced buttons, active-high, one-hot per colour.
- led  out  4  one-hot LED request.
- tone_en  out  1  tone request.
- tone_sel  out  3  0–3 colour tone, 4 error tone, 5 win tone.
- score  out  7  completed rounds, binary.
- busy  out  1  high in every state except IDLE.

## Operation
- Press edge: btn_q registered each clk; edge = btn & ~btn_q; any_edge = |edge.
- Free counter: 16-bit, increments every clk, reset 0.
- LFSR: 16-bit Fibonacci, step: s <= {s[14:0], s[15]^s[13]^s[12]^s[10]}; colour = s[1:0] after the step.
- States: IDLE, PLAY_ON, PLAY_GAP, INPUT, FB_ON, FB_GAP, LOSE, WIN.
- IDLE: outputs dark. any_edge -> seed <= free counter (16'hACE1 if 0), len <= 1, score <= 0, idx <= 0, lfsr <= seed, tick_cnt <= 0 -> PLAY_ON with one LFSR step.
- PLAY_ON: led = onehot(colour), tone_en = 1, tone_sel = colour; after ON_TICKS ticks -> PLAY_GAP.
- PLAY_GAP: dark; after GAP_TICKS ticks: if idx == len-1 -> INPUT with idx <= 0, lfsr <= seed; else idx++, step LFSR, -> PLAY_ON.
- Button edges in PLAY_* and FB_* are ignored.
- INPUT: dark. On any_edge, step LFSR to get expected colour. Correct iff edge == onehot(expected) (multi-bit edge is wrong). Correct -> FB_ON showing pressed colour; wrong -> LOSE.
- FB_ON: as PLAY_ON for the pressed colour, ON_TICKS ticks -> FB_GAP.
- FB_GAP: GAP_TICKS ticks, then: idx < len-1 -> idx++, INPUT; else score <= len; if len == MAX_LEN -> WIN; else len++, idx <= 0, lfsr <= seed, step -> PLAY_ON.
- LOSE: tone_en = 1, tone_sel = 4, led = 4'hF for LOSE_TICKS ticks -> IDLE. WIN: tone_sel = 5, led = 4'hF, LOSE_TICKS ticks -> IDLE.
- score holds its value in IDLE until the next game starts.

## Timing
- Reset: state IDLE; led 0, tone_en 0, tone_sel 0, score 0, busy 0, lfsr/seed/len/idx/tick_cnt 0, btn_q 0.
- Outputs are registered from state; they change the clk after the transition decision.
- Press to decision: 1 clk (edge register), FB_ON outputs visible 1 clk later.
- Tick counting: tick_cnt increments on tick, transition on the tick that makes it equal N, counter clears on every state change; a tick coinciding with entry is not counted.
- Simultaneous edge and tick in INPUT: edge wins, tick ignored.
- Button held from IDLE start is not re-counted (edge only).
- rst mid-game: immediate return to reset values, no tone tail.

## Configuration
- SIMON_TIMEOUT_EN defined: in INPUT, tick_cnt counts ticks since entry; reaching TIMEOUT_TICKS without any_edge -> LOSE. Counter cleared on each entry to INPUT.
- Undefined: INPUT waits indefinitely; no timeout counter logic is built.

## Test plan
- Params ON=2, GAP=1, LOSE=3, MAX_LEN=3. Reset asserted -> all outputs 0, busy 0.
- Press btn[0] at free counter 0 -> seed 16'hACE1; first PLAY_ON colour equals model LFSR step from ACE1; led onehot for exactly 2 ticks, dark 1 tick.
- Round 1 correct press -> FB_ON 2 ticks, score 1, playback replays 2 colours identical to model.
- Wrong press (or btn = 4'b0011 edge) in INPUT -> LOSE: tone_sel 4, led 4'hF for 3 ticks, then IDLE with score held.
- Three correct rounds -> score 3, WIN tone_sel 5 for 3 ticks, IDLE; next press clears score to 0.
- With SIMON_TIMEOUT_EN, TIMEOUT=5: no press for 5 ticks in INPUT -> LOSE; without macro, 100 ticks -> still INPUT; rst asserted during PLAY_ON -> outputs 0 next edge.

Source files
------------

// File: rtl/simon_game_ctrl.sv
// simon_game_ctrl: Simon round sequencer, LFSR colour replay, press checking; SIMON_TIMEOUT_EN adds an input timeout
`timescale 1ns/1ps
module simon_game_ctrl #(
`ifdef SIMON_TIMEOUT_EN
  parameter int TIMEOUT_TICKS = 3000,
`endif
  parameter int MAX_LEN    = 32,
  parameter int ON_TICKS   = 300,
  parameter int GAP_TICKS  = 100,
  parameter int LOSE_TICKS = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic [3:0] btn,
  output logic [3:0] led,
  output logic       tone_en,
  output logic [2:0] tone_sel,
  output logic [6:0] score,
  output logic       busy
);
  typedef enum logic [2:0] {IDLE, PLAY_ON, PLAY_GAP, INPUT, FB_ON, FB_GAP, LOSE, WIN} state_t;
  state_t state_q, state_d;
  logic [3:0] btn_q, press, led_q, led_d;
  logic any_press, tone_en_q, tone_en_d, busy_q, busy_d, on_done, gap_done, lose_done, show, alarm;
  logic [2:0] tone_sel_q, tone_sel_d;
  logic [15:0] free_q, lfsr_q, lfsr_d, lfsr_nxt, seed_q, seed_d, seed_new, tick_cnt_q, tick_cnt_d;
  logic [6:0] len_q, len_d, idx_q, idx_d, score_q, score_d;
`ifdef SIMON_TIMEOUT_EN
  logic to_done;
  assign to_done = tick && tick_cnt_q == 16'(TIMEOUT_TICKS - 1);
`endif
  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  assign press     = btn & ~btn_q;
  assign any_press = |press;
  assign lfsr_nxt  = step(lfsr_q);
  assign seed_new  = free_q == 16'd0 ? 16'hACE1 : free_q;
  assign on_done   = tick && tick_cnt_q == 16'(ON_TICKS - 1);
  assign gap_done  = tick && tick_cnt_q == 16'(GAP_TICKS - 1);
  assign lose_done = tick && tick_cnt_q == 16'(LOSE_TICKS - 1);
  assign led       = led_q;
  assign tone_en   = tone_en_q;
  assign tone_sel  = tone_sel_q;
  assign score     = score_q;
  assign busy      = busy_q;
  // round sequencing: next state, sequence position and the LFSR replay cursor
  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    seed_d     = seed_q;
    len_d      = len_q;
    idx_d      = idx_q;
    score_d    = score_q;
    tick_cnt_d = tick ? tick_cnt_q + 16'd1 : tick_cnt_q;
    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        if (any_press) begin
          seed_d  = seed_new;
          lfsr_d  = step(seed_new);
          len_d   = 7'd1;
          idx_d   = '0;
          score_d = '0;
          state_d = PLAY_ON;
        end
      end
      PLAY_ON: if (on_done) state_d = PLAY_GAP;
      PLAY_GAP: if (gap_done) begin
        if (idx_q == len_q - 7'd1) begin
          idx_d   = '0;
          lfsr_d  = seed_q;
          state_d = INPUT;
        end else begin
          idx_d   = idx_q + 7'd1;
          lfsr_d  = lfsr_nxt;
          state_d = PLAY_ON;
        end
      end
      INPUT: begin
`ifndef SIMON_TIMEOUT_EN
        tick_cnt_d = '0;
`endif
        if (any_press) begin
          lfsr_d  = lfsr_nxt;
          state_d = press == 4'b0001 << lfsr_nxt[1:0] ? FB_ON : LOSE;
        end
`ifdef SIMON_TIMEOUT_EN
        else if (to_done) state_d = LOSE;
`endif
      end
      FB_ON: if (on_done) state_d = FB_GAP;
      FB_GAP: if (gap_done) begin
        if (idx_q < len_q - 7'd1) begin
          idx_d   = idx_q + 7'd1;
          state_d = INPUT;
        end else begin
          score_d = len_q;
          if (len_q == 7'(MAX_LEN)) state_d = WIN;
          else begin
            len_d   = len_q + 7'd1;
            idx_d   = '0;
            lfsr_d  = step(seed_q);
            state_d = PLAY_ON;
          end
        end
      end
      default: if (lose_done) state_d = IDLE;
    endcase
    if (state_d != state_q) tick_cnt_d = '0;
  end
  // output requests decoded from the current state, registered one clk behind it
  always_comb begin
    show       = state_q == PLAY_ON || state_q == FB_ON;
    alarm      = state_q == LOSE || state_q == WIN;
    led_d      = show ? 4'b0001 << lfsr_q[1:0] : alarm ? 4'hF : 4'h0;
    tone_en_d  = show | alarm;
    tone_sel_d = show ? {1'b0, lfsr_q[1:0]} : state_q == LOSE ? 3'd4 : state_q == WIN ? 3'd5 : 3'd0;
    busy_d     = state_q != IDLE;
  end
  // state, game registers and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      btn_q      <= '0;
      free_q     <= '0;
      lfsr_q     <= '0;
      seed_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      score_q    <= '0;
      tick_cnt_q <= '0;
      led_q      <= '0;
      tone_en_q  <= 1'b0;
      tone_sel_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      btn_q      <= btn;
      free_q     <= free_q + 16'd1;
      lfsr_q     <= lfsr_d;
      seed_q     <= seed_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      score_q    <= score_d;
      tick_cnt_q <= tick_cnt_d;
      led_q      <= led_d;
      tone_en_q  <= tone_en_d;
      tone_sel_q <= tone_sel_d;
      busy_q     <= busy_d;
    end
  end
endmodule

// File: tb/tb_simon_game_ctrl.sv
// tb_simon_game_ctrl: directed bench for simon_game_ctrl with ON=2 GAP=1 LOSE=3 MAX_LEN=3
`timescale 1ns/1ps
module tb_simon_game_ctrl;
  logic clk = 1'b0, rst = 1'b1, tick = 1'b0;
  logic [3:0] btn = 4'h0;
  logic [3:0] led;
  logic tone_en, busy;
  logic [2:0] tone_sel;
  logic [6:0] score;
  int total = 0, bad = 0;
  logic [15:0] free_m = 16'd0, seed_m;
  simon_game_ctrl #(
`ifdef SIMON_TIMEOUT_EN
    .TIMEOUT_TICKS(5),
`endif
    .MAX_LEN(3), .ON_TICKS(2), .GAP_TICKS(1), .LOSE_TICKS(3)
  ) dut (
    .clk(clk), .rst(rst), .tick(tick), .btn(btn), .led(led),
    .tone_en(tone_en), .tone_sel(tone_sel), .score(score), .busy(busy)
  );
  always #5 clk = ~clk;
  // free-running counter model used to predict the seed
  always @(posedge clk or posedge rst)
    if (rst) free_m <= 16'd0;
    else free_m <= free_m + 16'd1;
  function automatic logic [15:0] step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic tk(input int n);
    repeat (n) begin
      tick = 1'b1;
      cyc();
      tick = 1'b0;
      cyc();
    end
  endtask
  task automatic start(input logic [3:0] b);
    seed_m = free_m == 16'd0 ? 16'hACE1 : free_m;
    btn = b;
    cyc();
    cyc();
  endtask
  task automatic play(input int n);
    logic [15:0] m;
    m = seed_m;
    for (int i = 0; i < n; i++) begin
      m = step(m);
      chk("play_led", 16'(led), 16'(4'b0001 << m[1:0]));
      chk("play_sel", 16'(tone_sel), 16'({1'b0, m[1:0]}));
      chk("play_ten", 16'(tone_en), 16'd1);
      tk(1);
      chk("play_hold", 16'(led), 16'(4'b0001 << m[1:0]));
      tk(1);
      chk("gap_dark", 16'(led), 16'd0);
      tk(1);
    end
  endtask
  task automatic answer(input int n);
    logic [15:0] m;
    logic [3:0] b;
    m = seed_m;
    for (int i = 0; i < n; i++) begin
      m = step(m);
      b = 4'b0001 << m[1:0];
      btn = b;
      cyc();
      chk("fb_latency", 16'(led), 16'd0);
      cyc();
      btn = 4'h0;
      chk("fb_led", 16'(led), 16'(b));
      chk("fb_sel", 16'(tone_sel), 16'({1'b0, m[1:0]}));
      tk(2);
      chk("fb_gap", 16'(led), 16'd0);
      tk(1);
    end
  endtask
  initial begin
    repeat (3) cyc();
    chk("rst_led", 16'(led), 16'd0);
    chk("rst_ten", 16'(tone_en), 16'd0);
    chk("rst_sel", 16'(tone_sel), 16'd0);
    chk("rst_score", 16'(score), 16'd0);
    chk("rst_busy", 16'(busy), 16'd0);
    rst = 1'b0;
    start(4'b0001);
    btn = 4'h0;
    chk("seed_ace1_col", 16'(led), 16'h8);
    chk("busy_on", 16'(busy), 16'd1);
    play(1);
    answer(1);
    chk("score1", 16'(score), 16'd1);
    play(2);
    answer(2);
    chk("score2", 16'(score), 16'd2);
    play(3);
    answer(3);
    chk("win_score", 16'(score), 16'd3);
    chk("win_sel", 16'(tone_sel), 16'd5);
    chk("win_led", 16'(led), 16'hF);
    chk("win_ten", 16'(tone_en), 16'd1);
    tk(2);
    chk("win_hold", 16'(tone_sel), 16'd5);
    tk(1);
    chk("win_idle_busy", 16'(busy), 16'd0);
    chk("win_idle_led", 16'(led), 16'd0);
    chk("win_idle_ten", 16'(tone_en), 16'd0);
    chk("win_score_held", 16'(score), 16'd3);
    cyc();
    start(4'b0001);
    btn = 4'h0;
    chk("new_game_score", 16'(score), 16'd0);
    play(1);
    answer(1);
    play(2);
    btn = 4'b0011;
    cyc();
    cyc();
    btn = 4'h0;
    chk("lose_led", 16'(led), 16'hF);
    chk("lose_sel", 16'(tone_sel), 16'd4);
    chk("lose_ten", 16'(tone_en), 16'd1);
    tk(2);
    chk("lose_hold", 16'(tone_sel), 16'd4);
    tk(1);
    chk("lose_idle_busy", 16'(busy), 16'd0);
    chk("lose_idle_led", 16'(led), 16'd0);
    chk("lose_score_held", 16'(score), 16'd1);
    cyc();
    start(4'b0010);
    play(1);
`ifdef SIMON_TIMEOUT_EN
    tk(4);
    chk("to_wait_led", 16'(led), 16'd0);
    chk("to_wait_busy", 16'(busy), 16'd1);
    tk(1);
    chk("to_lose_led", 16'(led), 16'hF);
    chk("to_lose_sel", 16'(tone_sel), 16'd4);
    tk(3);
    chk("to_idle_busy", 16'(busy), 16'd0);
`else
    tk(100);
    chk("wait_led", 16'(led), 16'd0);
    chk("wait_ten", 16'(tone_en), 16'd0);
    chk("wait_busy", 16'(busy), 16'd1);
`endif
    btn = 4'h0;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    start(4'b0001);
    btn = 4'h0;
    chk("d_led", 16'(led), 16'h8);
    tk(1);
    chk("d_hold", 16'(led), 16'h8);
    rst = 1'b1;
    cyc();
    chk("mid_rst_led", 16'(led), 16'd0);
    chk("mid_rst_ten", 16'(tone_en), 16'd0);
    chk("mid_rst_sel", 16'(tone_sel), 16'd0);
    chk("mid_rst_busy", 16'(busy), 16'd0);
    chk("mid_rst_score", 16'(score), 16'd0);
    rst = 1'b0;
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
